// File: rtl/wwfa_pkg.sv
`default_nettype none
// wwfa_pkg: shared constants and width helper for the wrapped wavefront arbiter blocks.
package wwfa_pkg;

  localparam int WWFA_N     = 4;
  localparam int MODE_FREE  = 0;
  localparam int MODE_GRANT = 1;
  localparam int DIR_RIGHT  = 0;
  localparam int DIR_LEFT   = 1;

  // Never returns less than 1 so N=2 still gets a usable one-bit offset field.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wwfa_barrel_rot.sv
`default_nettype none
// wwfa_barrel_rot: combinational log-stage rotator, vec rotated by amt positions (amt < N).
module wwfa_barrel_rot #(
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int DIR   = 0
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] amt,
  output logic [N-1:0]     rot
);

  logic [IDX_W:0][N-1:0] stage;

  assign stage[0] = vec;

  // Stage k rotates by 2^k mod N, so the stages compose correctly for any N.
  for (genvar k = 0; k < IDX_W; k++) begin : g_stage
    localparam int SH = (1 << k) % N;
    for (genvar i = 0; i < N; i++) begin : g_bit
      localparam int SRC = (DIR == 0) ? ((i + SH) % N) : ((i + N - SH) % N);
      assign stage[k+1][i] = amt[k] ? stage[k][SRC] : stage[k][i];
    end
  end

  assign rot = stage[IDX_W];

endmodule
`default_nettype wire

// File: rtl/wwfa_priority_rotator.sv
`default_nettype none
// wwfa_priority_rotator: rotating top-priority diagonal for the N-port wrapped wavefront arbiter.
module wwfa_priority_rotator
  import wwfa_pkg::*;
#(
  parameter int             N       = WWFA_N,
  parameter int             IDX_W   = clog2(N),
  parameter int             CNT_W   = 16,
  parameter int             MODE    = MODE_FREE,
  parameter int             DIR     = DIR_RIGHT,
  parameter logic [N-1:0]   RST_PAT = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [N-1:0]     load_data,
  input  logic             work,
  input  logic             grant_any,
  input  logic [IDX_W-1:0] step,
  output logic [N-1:0]     rot_vec,
  output logic             diag_bit,
  output logic [IDX_W-1:0] ptr,
  output logic             wrap,
  output logic [CNT_W-1:0] round_cnt,
  output logic             err
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

  logic [N-1:0]     base;
  logic [N-1:0]     rot_next;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] next_ptr;
  logic             adv;
  logic             step_ok;
  logic             step_bad;
  logic             next_wrap;

  always_comb begin
    adv       = work & ((MODE == MODE_FREE) | grant_any);
    sum       = {1'b0, ptr} + {1'b0, step};
    step_ok   = (step != '0) && ({1'b0, step} < N_EXT);
    step_bad  = ({1'b0, step} >= N_EXT);
    next_wrap = (sum >= N_EXT);
    next_ptr  = IDX_W'(next_wrap ? (sum - N_EXT) : sum);
  end

  wwfa_barrel_rot #(
    .N     (N),
    .IDX_W (IDX_W),
    .DIR   (DIR)
  ) u_rot (
    .vec (base),
    .amt (next_ptr),
    .rot (rot_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= RST_PAT;
      rot_vec   <= RST_PAT;
      ptr       <= '0;
      wrap      <= 1'b0;
      round_cnt <= '0;
      err       <= 1'b0;
    end else if (load) begin
      base      <= load_data;
      rot_vec   <= load_data;
      ptr       <= '0;
      wrap      <= 1'b0;
      round_cnt <= '0;
    end else if (adv && step_ok) begin
      ptr       <= next_ptr;
      rot_vec   <= rot_next;
      wrap      <= next_wrap;
      round_cnt <= round_cnt + CNT_W'(1);
    end else begin
      // Zero or out-of-range steps never move the pointer; only the latter is an error.
      wrap <= 1'b0;
      if (adv && step_bad) err <= 1'b1;
    end
  end

  assign diag_bit = rot_vec[0];

endmodule
`default_nettype wire

// File: tb/tb_wwfa_priority_rotator.sv
`default_nettype none
// tb_wwfa_priority_rotator: three rotator configurations driven in parallel, scoreboarded against a reference model.
module tb_wwfa_priority_rotator;

  typedef struct {
    logic [7:0] base;
    int         ptr;
    int         cnt;
    bit         wrap;
    bit         err;
  } mstate_t;

  typedef struct {
    logic [7:0] rot;
    int         ptr;
    int         cnt;
    bit         wrap;
    bit         err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic [4:0] load_data;
  logic       work;
  logic       grant_any;
  logic [2:0] step;

  logic [3:0]  rot_a, rot_b;
  logic [4:0]  rot_c;
  logic        diag_a, diag_b, diag_c;
  logic [1:0]  ptr_a, ptr_b;
  logic [2:0]  ptr_c;
  logic        wrap_a, wrap_b, wrap_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;
  logic        err_a, err_b, err_c;

  int total_checks;
  int passed_checks;

  mstate_t sa, sb, sc;
  exp_t    qa[$], qb[$], qc[$];

  wwfa_priority_rotator #(.N(4), .CNT_W(16), .MODE(0), .DIR(0)) dut_a (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data[3:0]), .work(work),
    .grant_any(grant_any), .step(step[1:0]), .rot_vec(rot_a), .diag_bit(diag_a),
    .ptr(ptr_a), .wrap(wrap_a), .round_cnt(cnt_a), .err(err_a));

  wwfa_priority_rotator #(.N(4), .CNT_W(16), .MODE(1), .DIR(0)) dut_b (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data[3:0]), .work(work),
    .grant_any(grant_any), .step(step[1:0]), .rot_vec(rot_b), .diag_bit(diag_b),
    .ptr(ptr_b), .wrap(wrap_b), .round_cnt(cnt_b), .err(err_b));

  wwfa_priority_rotator #(.N(5), .CNT_W(2), .MODE(0), .DIR(1), .RST_PAT(5'b00001)) dut_c (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data), .work(work),
    .grant_any(grant_any), .step(step), .rot_vec(rot_c), .diag_bit(diag_c),
    .ptr(ptr_c), .wrap(wrap_c), .round_cnt(cnt_c), .err(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: one clock of the rotator's register-transfer rules.
  function automatic mstate_t mstep(mstate_t s, int n, int mode, int cntw, bit r, bit l,
                                     logic [7:0] ld, bit w, bit g, int st);
    mstate_t o;
    int      sum;
    o      = s;
    o.wrap = 1'b0;
    if (r) begin
      o.base = 8'd1; o.ptr = 0; o.cnt = 0; o.err = 1'b0;
    end else if (l) begin
      o.base = ld; o.ptr = 0; o.cnt = 0;
    end else if (w && (mode == 0 || g)) begin
      if (st >= 1 && st < n) begin
        sum    = s.ptr + st;
        o.wrap = (sum >= n);
        o.ptr  = sum % n;
        o.cnt  = (s.cnt + 1) % (1 << cntw);
      end else if (st >= n) begin
        o.err = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic exp_t mexp(mstate_t s, int n, int dir);
    exp_t e;
    e.rot = '0;
    for (int i = 0; i < n; i++) begin
      e.rot[i] = (dir == 0) ? s.base[(i + s.ptr) % n] : s.base[(i - s.ptr + n) % n];
    end
    e.ptr = s.ptr; e.cnt = s.cnt; e.wrap = s.wrap; e.err = s.err;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_out(input string tag, input exp_t e, input logic [7:0] rot, input logic [31:0] p,
                           input logic [31:0] c, input logic wr, input logic er, input logic dg);
    chk({tag, ".rot_vec"}, {24'd0, rot}, {24'd0, e.rot});
    chk({tag, ".ptr"}, p, e.ptr);
    chk({tag, ".round_cnt"}, c, e.cnt);
    chk({tag, ".wrap"}, {31'd0, wr}, {31'd0, e.wrap});
    chk({tag, ".err"}, {31'd0, er}, {31'd0, e.err});
    chk({tag, ".diag_bit"}, {31'd0, dg}, {31'd0, e.rot[0]});
  endtask

  // Monitor: every clock edge the DUTs present one registered result per queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check_out("A", e, {4'd0, rot_a}, {30'd0, ptr_a}, {16'd0, cnt_a}, wrap_a, err_a, diag_a);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check_out("B", e, {4'd0, rot_b}, {30'd0, ptr_b}, {16'd0, cnt_b}, wrap_b, err_b, diag_b);
    end
    if (qc.size() > 0) begin
      e = qc.pop_front();
      check_out("C", e, {3'd0, rot_c}, {29'd0, ptr_c}, {30'd0, cnt_c}, wrap_c, err_c, diag_c);
    end
  end

  task automatic cyc(input bit r, input bit l, input logic [4:0] ld, input bit w, input bit g,
                     input logic [2:0] st);
    reset = r; load = l; load_data = ld; work = w; grant_any = g; step = st;
    sa = mstep(sa, 4, 0, 16, r, l, {4'd0, ld[3:0]}, w, g, int'(st[1:0]));
    sb = mstep(sb, 4, 1, 16, r, l, {4'd0, ld[3:0]}, w, g, int'(st[1:0]));
    sc = mstep(sc, 5, 0, 2, r, l, {3'd0, ld}, w, g, int'(st));
    qa.push_back(mexp(sa, 4, 0));
    qb.push_back(mexp(sb, 4, 0));
    qc.push_back(mexp(sc, 5, 1));
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total_checks = 0;
    passed_checks = 0;
    reset = 1'b0; load = 1'b0; load_data = '0; work = 1'b0; grant_any = 1'b0; step = 3'd1;
    #2;
    cyc(1, 0, 5'b0, 0, 0, 1);
    repeat (4) cyc(0, 0, 5'b0, 1, 1, 1);
    cyc(0, 1, 5'b00011, 1, 1, 1);
    cyc(0, 0, 5'b0, 1, 1, 3);
    cyc(0, 0, 5'b0, 1, 1, 1);
    cyc(0, 0, 5'b0, 1, 0, 1);
    cyc(0, 0, 5'b0, 1, 1, 1);
    cyc(0, 0, 5'b0, 1, 1, 7);
    cyc(0, 1, 5'b10110, 0, 0, 1);
    cyc(0, 0, 5'b0, 1, 1, 0);
    cyc(1, 0, 5'b0, 0, 0, 1);
    cyc(0, 0, 5'b0, 1, 1, 0);
    repeat (2) cyc(0, 0, 5'b0, 1, 1, 1);
    cyc(1, 1, 5'b11111, 1, 1, 1);
    repeat (5) cyc(0, 0, 5'b0, 1, 1, 1);
    cyc(0, 0, 5'b0, 0, 1, 2);
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, 5'($urandom),
          $urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom_range(0, 7)));
    end
    cyc(0, 0, 5'b0, 0, 0, 1);
    @(posedge clk);
    #2;
    chk("queues_drained", qa.size() + qb.size() + qc.size(), 0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
`default_nettype wire
